// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per cycle, with a valid/ready handshake on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int STEPS      = WIDTH / DIGIT_SAFE;
    localparam int CNT_W      = $clog2(STEPS + 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_digit_range
            $error("serial_adder: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
        end else if ((WIDTH % DIGIT_SAFE) != 0) begin : g_bad_digit_div
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               accept;
    logic               last_step;
    logic [DIGIT_SAFE-1:0] a_slice;
    logic [DIGIT_SAFE-1:0] b_slice;
    logic [DIGIT_SAFE:0]   step_res;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == BUSY) && (cnt_q == CNT_W'(STEPS - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs; in_ready is masked by rst so nothing is taken on a reset edge
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // Slice selection and one digit of addition
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_slice = a_q[k*DIGIT_SAFE +: DIGIT_SAFE];
                b_slice = b_q[k*DIGIT_SAFE +: DIGIT_SAFE];
            end
        end
        step_res = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT_SAFE{1'b0}}, carry_q};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            BUSY: begin
                for (int k = 0; k < STEPS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*DIGIT_SAFE +: DIGIT_SAFE] = step_res[DIGIT_SAFE-1:0];
                    end
                end
                carry_d = step_res[DIGIT_SAFE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    cout_d = step_res[DIGIT_SAFE];
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB recovered from the MSB operand bits and the MSB result bit
                    ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ step_res[DIGIT_SAFE-1]
                             ^ step_res[DIGIT_SAFE];
`endif
                end
            end
            default: ;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four instances (DIGIT = 1, 2, 4, 8) at WIDTH = 8.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid_s  [4];
    logic       in_ready_s  [4];
    logic [7:0] a_s         [4];
    logic [7:0] b_s         [4];
    logic       cin_s       [4];
    logic       out_valid_s [4];
    logic       out_ready_s [4];
    logic [7:0] sum_s       [4];
    logic       cout_s      [4];
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf_s       [4];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            serial_adder #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid_s[gi]),
                .in_ready  (in_ready_s[gi]),
                .a         (a_s[gi]),
                .b         (b_s[gi]),
                .cin       (cin_s[gi]),
                .out_valid (out_valid_s[gi]),
                .out_ready (out_ready_s[gi]),
                .sum       (sum_s[gi]),
`ifdef SERIAL_ADDER_OVF_EN
                .ovf       (ovf_s[gi]),
`endif
                .cout      (cout_s[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input int d, input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci);
        exp_t       e;
        logic [8:0] full;
        full   = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = av[7] ^ bv[7] ^ full[7] ^ full[8];
        e.lat  = 8 >> d;
        return e;
    endfunction

    // Present one operand pair, scramble inputs after acceptance, wait (bounded) for out_valid.
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          output int lat, output logic [7:0] s, output logic co,
                          output logic ov, output logic rdy_seen);
        @(negedge clk);
        in_valid_s[d]  = 1'b1;
        a_s[d]         = av;
        b_s[d]         = bv;
        cin_s[d]       = ci;
        out_ready_s[d] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_s[d] = 1'b0;
        a_s[d]        = ~av;
        b_s[d]        = ~bv;
        cin_s[d]      = ~ci;
        rdy_seen      = 1'b0;
        lat           = 0;
        while (!out_valid_s[d] && lat < 64) begin
            rdy_seen = rdy_seen | in_ready_s[d];
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid_s[d]) lat = -1;
        rdy_seen = rdy_seen | in_ready_s[d];
        s  = sum_s[d];
        co = cout_s[d];
`ifdef SERIAL_ADDER_OVF_EN
        ov = ovf_s[d];
`else
        ov = 1'b0;
`endif
        $display("op d=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 1 << d, av, bv, ci, s, co, ov, lat);
    endtask

    task automatic release_out(input int d);
        @(negedge clk);
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[d] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0;
            a_s[d] = 8'h00; b_s[d] = 8'h00; cin_s[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks += 4;
            if (out_valid_s[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid d=%0d got %b exp 0", d, out_valid_s[d]); end
            if (in_ready_s[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready d=%0d got %b exp 0", d, in_ready_s[d]); end
            if (sum_s[d] !== 8'h00) begin errors++; $display("FAIL reset_sum d=%0d got %h exp 00", d, sum_s[d]); end
            if (cout_s[d] !== 1'b0) begin errors++; $display("FAIL reset_cout d=%0d got %b exp 0", d, cout_s[d]); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (in_ready_s[d] !== 1'b1) begin errors++; $display("FAIL idle_in_ready d=%0d got %b exp 1", d, in_ready_s[d]); end
        end
    endtask

    task automatic test_digit1;
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs;
        sb.push_back(model(0, 8'hFF, 8'h01, 1'b0));
        run_op(0, 8'hFF, 8'h01, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat) begin errors++; $display("FAIL d1_latency got %0d exp %0d", lat, e.lat); end
        if (s !== e.sum) begin errors++; $display("FAIL d1_sum got %h exp %h", s, e.sum); end
        if (co !== e.cout) begin errors++; $display("FAIL d1_cout got %b exp %b", co, e.cout); end
        release_out(0);
        checks += 2;
        if (in_ready_s[0] !== 1'b1) begin errors++; $display("FAIL d1_in_ready_after got %b exp 1", in_ready_s[0]); end
        if (out_valid_s[0] !== 1'b0) begin errors++; $display("FAIL d1_out_valid_after got %b exp 0", out_valid_s[0]); end
    endtask

    task automatic test_digit4;
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs;
        sb.push_back(model(2, 8'h3C, 8'h45, 1'b1));
        run_op(2, 8'h3C, 8'h45, 1'b1, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 4;
        if (lat !== e.lat) begin errors++; $display("FAIL d4_latency got %0d exp %0d", lat, e.lat); end
        if (s !== e.sum) begin errors++; $display("FAIL d4_sum got %h exp %h", s, e.sum); end
        if (co !== e.cout) begin errors++; $display("FAIL d4_cout got %b exp %b", co, e.cout); end
        if (rs !== 1'b0) begin errors++; $display("FAIL d4_in_ready_busy_done got %b exp 0", rs); end
        release_out(2);
    endtask

    task automatic test_backpressure;
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs;
        sb.push_back(model(1, 8'h9A, 8'hB7, 1'b0));
        run_op(1, 8'h9A, 8'hB7, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, e.lat); end
        if (s !== e.sum) begin errors++; $display("FAIL bp_sum got %h exp %h", s, e.sum); end
        if (co !== e.cout) begin errors++; $display("FAIL bp_cout got %b exp %b", co, e.cout); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_s[1] = 1'b1;
            a_s[1] = 8'($urandom); b_s[1] = 8'($urandom); cin_s[1] = 1'($urandom);
            @(posedge clk);
            #1;
            in_valid_s[1] = 1'b0;
            checks += 4;
            if (out_valid_s[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b exp 1", i, out_valid_s[1]); end
            if (sum_s[1] !== e.sum) begin errors++; $display("FAIL bp_hold_sum cyc=%0d got %h exp %h", i, sum_s[1], e.sum); end
            if (cout_s[1] !== e.cout) begin errors++; $display("FAIL bp_hold_cout cyc=%0d got %b exp %b", i, cout_s[1], e.cout); end
            if (in_ready_s[1] !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got %b exp 0", i, in_ready_s[1]); end
        end
        release_out(1);
        checks += 2;
        if (in_ready_s[1] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready_s[1]); end
        if (out_valid_s[1] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid_s[1]); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid_s[1] !== 1'b0) begin errors++; $display("FAIL bp_no_ghost_op got %b exp 0", out_valid_s[1]); end
    endtask

    task automatic test_reset_mid_op;
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs; logic seen;
        @(negedge clk);
        in_valid_s[0] = 1'b1; a_s[0] = 8'h55; b_s[0] = 8'h0F; cin_s[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid_s[0] = 1'b1; a_s[0] = 8'h11; b_s[0] = 8'h22; cin_s[0] = 1'b0;
        @(posedge clk);
        #1;
        checks += 4;
        if (out_valid_s[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid_s[0]); end
        if (sum_s[0] !== 8'h00) begin errors++; $display("FAIL mid_rst_sum got %h exp 00", sum_s[0]); end
        if (cout_s[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_cout got %b exp 0", cout_s[0]); end
        if (in_ready_s[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready_s[0]); end
        @(negedge clk);
        rst = 1'b0;
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready_s[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got %b exp 1", in_ready_s[0]); end
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_s[0];
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_discarded got %b exp 0", seen); end
        sb.push_back(model(0, 8'h10, 8'h20, 1'b0));
        run_op(0, 8'h10, 8'h20, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat) begin errors++; $display("FAIL mid_rst_next_latency got %0d exp %0d", lat, e.lat); end
        if (s !== e.sum) begin errors++; $display("FAIL mid_rst_next_sum got %h exp %h", s, e.sum); end
        if (co !== e.cout) begin errors++; $display("FAIL mid_rst_next_cout got %b exp %b", co, e.cout); end
        release_out(0);
    endtask

    task automatic test_back_to_back;
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs;
        sb.push_back(model(3, 8'h12, 8'h34, 1'b0));
        run_op(3, 8'h12, 8'h34, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 2;
        if (lat !== e.lat) begin errors++; $display("FAIL b2b_first_latency got %0d exp %0d", lat, e.lat); end
        if (s !== e.sum) begin errors++; $display("FAIL b2b_first_sum got %h exp %h", s, e.sum); end
        // New operands presented on the same edge as the result handshake
        @(negedge clk);
        out_ready_s[3] = 1'b1;
        in_valid_s[3] = 1'b1; a_s[3] = 8'hA0; b_s[3] = 8'h70; cin_s[3] = 1'b1;
        sb.push_back(model(3, 8'hA0, 8'h70, 1'b1));
        @(posedge clk);
        #1;
        out_ready_s[3] = 1'b0;
        checks += 2;
        if (out_valid_s[3] !== 1'b0) begin errors++; $display("FAIL b2b_handshake_out_valid got %b exp 0", out_valid_s[3]); end
        if (in_ready_s[3] !== 1'b1) begin errors++; $display("FAIL b2b_handshake_in_ready got %b exp 1", in_ready_s[3]); end
        @(posedge clk);
        #1;
        in_valid_s[3] = 1'b0;
        lat = 0;
        while (!out_valid_s[3] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid_s[3]) lat = -1;
        e = sb.pop_front();
        $display("op d=8 a=a0 b=70 cin=1 -> sum=%h cout=%0d lat=%0d", sum_s[3], cout_s[3], lat);
        checks += 3;
        if (lat !== e.lat) begin errors++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, e.lat); end
        if (sum_s[3] !== e.sum) begin errors++; $display("FAIL b2b_second_sum got %h exp %h", sum_s[3], e.sum); end
        if (cout_s[3] !== e.cout) begin errors++; $display("FAIL b2b_second_cout got %b exp %b", cout_s[3], e.cout); end
        release_out(3);
    endtask

    task automatic test_ovf;
`ifdef SERIAL_ADDER_OVF_EN
        exp_t e; int lat; logic [7:0] s; logic co, ov, rs;
        sb.push_back(model(3, 8'h7F, 8'h01, 1'b0));
        run_op(3, 8'h7F, 8'h01, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 3;
        if (s !== e.sum) begin errors++; $display("FAIL ovf_pos_sum got %h exp %h", s, e.sum); end
        if (co !== e.cout) begin errors++; $display("FAIL ovf_pos_cout got %b exp %b", co, e.cout); end
        if (ov !== e.ovf) begin errors++; $display("FAIL ovf_pos_ovf got %b exp %b", ov, e.ovf); end
        release_out(3);
        sb.push_back(model(0, 8'hFF, 8'h01, 1'b0));
        run_op(0, 8'hFF, 8'h01, 1'b0, lat, s, co, ov, rs);
        e = sb.pop_front();
        checks += 2;
        if (s !== e.sum) begin errors++; $display("FAIL ovf_wrap_sum got %h exp %h", s, e.sum); end
        if (ov !== e.ovf) begin errors++; $display("FAIL ovf_wrap_ovf got %b exp %b", ov, e.ovf); end
        release_out(0);
`endif
    endtask

    task automatic test_random;
        exp_t e; int lat; int d; logic [7:0] av, bv, s; logic ci, co, ov, rs;
        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(3, 0));
            av = 8'($urandom);
            bv = 8'($urandom);
            ci = 1'($urandom);
            sb.push_back(model(d, av, bv, ci));
            run_op(d, av, bv, ci, lat, s, co, ov, rs);
            e = sb.pop_front();
            checks += 3;
            if (lat !== e.lat) begin errors++; $display("FAIL rand_latency i=%0d d=%0d got %0d exp %0d", i, 1 << d, lat, e.lat); end
            if (s !== e.sum) begin errors++; $display("FAIL rand_sum i=%0d d=%0d got %h exp %h", i, 1 << d, s, e.sum); end
            if (co !== e.cout) begin errors++; $display("FAIL rand_cout i=%0d d=%0d got %b exp %b", i, 1 << d, co, e.cout); end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (ov !== e.ovf) begin errors++; $display("FAIL rand_ovf i=%0d d=%0d got %b exp %b", i, 1 << d, ov, e.ovf); end
`endif
            release_out(d);
        end
    endtask

    initial begin
        test_reset();
        test_digit1();
        test_digit4();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_ovf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
